// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and
// the iteration counter width helper.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The counter must be able to hold N itself, hence N+1 distinct values.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] r,
  input  logic         q_msb,
  input  logic [N-1:0] d,
  output logic [N-1:0] r_next,
  output logic         q_bit
);

  logic [N:0] s;
  logic [N:0] t;

  // One extra bit keeps the shifted remainder from overflowing before the compare.
  assign s      = {r, q_msb};
  assign t      = s - {1'b0, d};
  assign q_bit  = ~t[N];
  assign r_next = t[N] ? s[N-1:0] : t[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider producing one quotient bit per clock, with a
// start/ready handshake and a one-cycle done pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  div_state_t    state, state_next;
  logic [CW-1:0] cnt;
  logic [N-1:0]  r_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  d_reg;
  logic [N-1:0]  r_next;
  logic          q_bit;
  logic          accept;
  logic          last_iter;
  logic [N-1:0]  q_shifted;

  assign ready     = (state == IDLE);
  assign done      = (state == DONE);
  assign accept    = ready && start;
  assign last_iter = (cnt == CW'(1));
  assign q_shifted = {q_reg[N-2:0], q_bit};

  div_step #(.N(N)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[N-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result registers load only on the edge that enters DONE, so they stay
  // stable across the whole next operation until its own completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_reg <= divisor;
      r_reg <= '0;
      q_reg <= dividend;
      cnt   <= CW'(N);
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      r_reg <= r_next;
      q_reg <= q_shifted;
      cnt   <= cnt - CW'(1);
      if (last_iter) begin
        quotient    <= q_shifted;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against plain integer division.
module tb_seq_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         ready;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q = '0;
  logic [N-1:0] exp_r = '0;
  logic         exp_z = 1'b0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Waits for done after an accept already happened; checks latency, that
  // ready stayed low and the old result held, then the new result.
  task automatic waitResult(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    int cycles;
    bit stable;
    bit ready_low;
    logic [N-1:0] nq, nr;
    logic nz;
    model(a, b, nq, nr, nz);
    cycles = 1;
    stable = 1;
    ready_low = 1;
    while (done !== 1'b1 && cycles < 100) begin
      if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_z) stable = 0;
      if (ready !== 1'b0) ready_low = 0;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 64'(cycles), (b == 0) ? 64'd1 : 64'(N + 1));
    checkOutput({tag, "_hold"}, 64'(stable), 64'd1);
    checkOutput({tag, "_ready_low"}, 64'(ready_low & ~ready), 64'd1);
    checkOutput({tag, "_quotient"}, 64'(quotient), 64'(nq));
    checkOutput({tag, "_remainder"}, 64'(remainder), 64'(nr));
    checkOutput({tag, "_dbz"}, 64'(div_by_zero), 64'(nz));
    exp_q = nq;
    exp_r = nr;
    exp_z = nz;
  endtask

  task automatic applyStimulus(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    checkOutput({tag, "_ready_idle"}, 64'(ready), 64'd1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    waitResult(tag, a, b);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_ready_after"}, 64'(ready), 64'd1);
  endtask

  initial begin
    bit saw_done;
    logic [N-1:0] ra, rb;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_quotient", 64'(quotient), 64'd0);
    checkOutput("reset_remainder", 64'(remainder), 64'd0);
    checkOutput("reset_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    applyStimulus("d100_7", 32'd100, 32'd7);
    applyStimulus("d5_9", 32'd5, 32'd9);
    applyStimulus("max_1", 32'hFFFF_FFFF, 32'd1);
    applyStimulus("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("dbz", 32'h1234, 32'd0);
    applyStimulus("d10_3", 32'd10, 32'd3);
    applyStimulus("dbz_b2b1", 32'hABCD, 32'd0);
    applyStimulus("dbz_b2b2", 32'd77, 32'd0);

    // start stays high with other operands through RUN and DONE
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk); #1;
    dividend = 32'd50;
    divisor  = 32'd6;
    waitResult("ignored", 32'd100, 32'd7);
    @(posedge clk); #1;
    checkOutput("ignored_done_pulse", 64'(done), 64'd0);
    checkOutput("ignored_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    waitResult("second", 32'd50, 32'd6);
    @(posedge clk); #1;

    // reset during iteration 10 aborts without a done pulse
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk); #1;
    start    = 1'b0;
    saw_done = 0;
    repeat (9) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_no_done", 64'(saw_done | done), 64'd0);
    checkOutput("abort_ready", 64'(ready), 64'd1);
    checkOutput("abort_quotient", 64'(quotient), 64'd0);
    checkOutput("abort_remainder", 64'(remainder), 64'd0);
    checkOutput("abort_dbz", 64'(div_by_zero), 64'd0);
    exp_q = '0;
    exp_r = '0;
    exp_z = 1'b0;
    applyStimulus("after_abort", 32'd100, 32'd7);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        default: rb = ra >> $urandom_range(0, 31);
      endcase
      applyStimulus("random", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
